// File: rtl/hazard_fwd_unit.sv
// Forwarding and hazard controller for the pipelined MIPS core: decodes the
// instruction entering EX, tracks recent producers, drives bypass selects, stalls and flushes.
module hazard_fwd_unit #(
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int BR_FLUSH  = 1,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic              branch_taken,
    output logic              issue_valid,
    output logic              stall,
    output logic              flush,
    output logic [2:0]        fwd_sel_a,
    output logic [2:0]        fwd_sel_b,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] dest;
        logic       is_load;
    } hist_t;

    localparam logic [1:0] BR_FLUSH_C = 2'(BR_FLUSH);

    hist_t       hist [1:FWD_DEPTH];
    hist_t       dec_entry;
    logic [1:0]  flush_cnt;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reads_rs;
    logic        reads_rt;

    logic [2:0]  sel_a_raw;
    logic [2:0]  sel_b_raw;
    logic        load_hit;
    logic        flush_active;
    logic        stall_int;
    logic        issue_int;

    assign op    = instruction[31:26];
    assign rs    = instruction[25:21];
    assign rt    = instruction[20:16];
    assign rd    = instruction[15:11];
    assign funct = instruction[5:0];

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        dec_entry = '0;
        reads_rs  = 1'b0;
        reads_rt  = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100011, 6'b100111, 6'b101011: begin
                        dec_entry.we   = 1'b1;
                        dec_entry.dest = rd;
                        reads_rs       = 1'b1;
                        reads_rt       = 1'b1;
                    end
                    6'b001000: reads_rs = 1'b1;
                    default: ;
                endcase
            end
            6'b001000: begin
                dec_entry.we   = 1'b1;
                dec_entry.dest = rt;
                reads_rs       = 1'b1;
            end
            6'b100011: begin
                dec_entry.we      = 1'b1;
                dec_entry.dest    = rt;
                dec_entry.is_load = 1'b1;
                reads_rs          = 1'b1;
            end
            6'b101011: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            6'b000001: reads_rs = 1'b1;
            default: ;
        endcase
        // $0 is hardwired, so a write to it is no write at all.
        if (dec_entry.dest == 5'd0) begin
            dec_entry.we      = 1'b0;
            dec_entry.is_load = 1'b0;
        end
        dec_entry.valid = 1'b1;
    end

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
        sel_a_raw = 3'd0;
        sel_b_raw = 3'd0;
        load_hit  = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (hist[k].valid && hist[k].we) begin
                if (reads_rs && hist[k].dest == rs)
                    sel_a_raw = 3'(k);
                if (reads_rt && hist[k].dest == rt)
                    sel_b_raw = 3'(k);
                if (k <= LOAD_LAT && hist[k].is_load &&
                    ((reads_rs && hist[k].dest == rs) ||
                     (reads_rt && hist[k].dest == rt)))
                    load_hit = 1'b1;
            end
        end
    end

    assign flush_active = in_valid && (flush_cnt != 2'd0);
    assign stall_int    = in_valid && !flush_active && load_hit;
    assign issue_int    = in_valid && !stall_int && !flush_active;

    assign issue_valid = issue_int & ~rst;
    assign stall       = stall_int & ~rst;
    assign flush       = flush_active & ~rst;
    assign fwd_sel_a   = rst ? 3'd0 : sel_a_raw;
    assign fwd_sel_b   = rst ? 3'd0 : sel_b_raw;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 2'd0;
        end else if (branch_taken) begin
            flush_cnt <= BR_FLUSH_C;
        end else if (flush_cnt != 2'd0) begin
            flush_cnt <= flush_cnt - 2'd1;
        end
    end

    // NOTE: the history is reset on purpose; stale valid bits would forward garbage after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= FWD_DEPTH; k++)
                hist[k] <= '0;
        end else begin
            hist[1] <= issue_int ? dec_entry : '0;
            for (int k = 2; k <= FWD_DEPTH; k++)
                hist[k] <= hist[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_int && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: three parameterisations share one stimulus stream.
module tb_hazard_fwd_unit;

    localparam logic [31:0] ADDI_1   = 32'h20010005;
    localparam logic [31:0] SUBU_312 = 32'h00221823;
    localparam logic [31:0] LW_4     = 32'h8C240000;
    localparam logic [31:0] NOR_544  = 32'h00842827;
    localparam logic [31:0] ADDI_0   = 32'h20000001;
    localparam logic [31:0] SUBU_300 = 32'h00001823;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction;
    logic        branch_taken;

    // u_d: FWD_DEPTH=2, LOAD_LAT=1, BR_FLUSH=1, STAT_W=2
    logic        iv_d, st_d, fl_d;
    logic [2:0]  fa_d, fb_d;
    logic [1:0]  sc_d;
    // u_b: FWD_DEPTH=1, LOAD_LAT=0, BR_FLUSH=0
    logic        iv_b, st_b, fl_b;
    logic [2:0]  fa_b, fb_b;
    logic [15:0] sc_b;
    // u_c: FWD_DEPTH=2, LOAD_LAT=0, BR_FLUSH=2
    logic        iv_c, st_c, fl_c;
    logic [2:0]  fa_c, fb_c;
    logic [15:0] sc_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.FWD_DEPTH(2), .LOAD_LAT(1), .BR_FLUSH(1), .STAT_W(2)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .branch_taken(branch_taken), .issue_valid(iv_d), .stall(st_d), .flush(fl_d),
        .fwd_sel_a(fa_d), .fwd_sel_b(fb_d), .stall_cnt(sc_d));

    hazard_fwd_unit #(.FWD_DEPTH(1), .LOAD_LAT(0), .BR_FLUSH(0), .STAT_W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .branch_taken(branch_taken), .issue_valid(iv_b), .stall(st_b), .flush(fl_b),
        .fwd_sel_a(fa_b), .fwd_sel_b(fb_b), .stall_cnt(sc_b));

    hazard_fwd_unit #(.FWD_DEPTH(2), .LOAD_LAT(0), .BR_FLUSH(2), .STAT_W(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .branch_taken(branch_taken), .issue_valid(iv_c), .stall(st_c), .flush(fl_c),
        .fwd_sel_a(fa_c), .fwd_sel_b(fb_c), .stall_cnt(sc_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a slot at posedge+1, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [31:0] ins, input logic bt);
        in_valid     = v;
        instruction  = ins;
        branch_taken = bt;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, ADDI_1, 1'b0);
        #3;
        check("rst issue_valid", {31'd0, iv_d}, 32'd0);
        check("rst stall",       {31'd0, st_d}, 32'd0);
        check("rst flush",       {31'd0, fl_d}, 32'd0);
        check("rst stall_cnt",   {30'd0, sc_d}, 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back RAW
        drive(1'b1, ADDI_1, 1'b0);
        check("raw1 issue", {31'd0, iv_d}, 32'd1);
        tick();
        drive(1'b1, SUBU_312, 1'b0);
        check("raw1 sel_a", {29'd0, fa_d}, 32'd1);
        check("raw1 sel_b", {29'd0, fb_d}, 32'd0);
        check("raw1 stall", {31'd0, st_d}, 32'd0);
        tick();

        // Distance 2
        drive(1'b1, ADDI_1, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0);
        tick();
        drive(1'b1, SUBU_312, 1'b0);
        check("dist2 sel_a",        {29'd0, fa_d}, 32'd2);
        check("dist2 depth1 sel_a", {29'd0, fa_b}, 32'd0);
        check("dist2 ll0 sel_a",    {29'd0, fa_c}, 32'd2);
        tick();

        // Load-use
        drive(1'b1, LW_4, 1'b0);
        tick();
        drive(1'b1, NOR_544, 1'b0);
        check("lu stall",       {31'd0, st_d}, 32'd1);
        check("lu issue",       {31'd0, iv_d}, 32'd0);
        check("lu ll0 stall",   {31'd0, st_c}, 32'd0);
        check("lu ll0 sel_a",   {29'd0, fa_c}, 32'd1);
        check("lu ll0 issue",   {31'd0, iv_c}, 32'd1);
        tick();
        drive(1'b1, NOR_544, 1'b0);
        check("lu2 stall",     {31'd0, st_d}, 32'd0);
        check("lu2 sel_a",     {29'd0, fa_d}, 32'd2);
        check("lu2 sel_b",     {29'd0, fb_d}, 32'd2);
        check("lu2 issue",     {31'd0, iv_d}, 32'd1);
        check("lu2 stall_cnt", {30'd0, sc_d}, 32'd1);
        tick();

        // $0 filter
        drive(1'b1, ADDI_0, 1'b0);
        tick();
        drive(1'b1, SUBU_300, 1'b0);
        check("r0 sel_a", {29'd0, fa_d}, 32'd0);
        check("r0 sel_b", {29'd0, fb_d}, 32'd0);
        tick();

        // Flush
        drive(1'b0, 32'd0, 1'b1);
        check("br cycle flush", {31'd0, fl_c}, 32'd0);
        tick();
        drive(1'b1, ADDI_1, 1'b0);
        check("fl1 br2 flush",  {31'd0, fl_c}, 32'd1);
        check("fl1 br2 issue",  {31'd0, iv_c}, 32'd0);
        check("fl1 br1 flush",  {31'd0, fl_d}, 32'd1);
        check("fl1 br0 flush",  {31'd0, fl_b}, 32'd0);
        check("fl1 br0 issue",  {31'd0, iv_b}, 32'd1);
        tick();
        drive(1'b1, ADDI_1, 1'b0);
        check("fl2 br2 flush",  {31'd0, fl_c}, 32'd1);
        check("fl2 br2 issue",  {31'd0, iv_c}, 32'd0);
        check("fl2 br1 flush",  {31'd0, fl_d}, 32'd0);
        check("fl2 br1 issue",  {31'd0, iv_d}, 32'd1);
        tick();
        drive(1'b1, SUBU_312, 1'b0);
        check("fl3 br2 flush",  {31'd0, fl_c}, 32'd0);
        check("fl3 br2 issue",  {31'd0, iv_c}, 32'd1);
        check("fl3 br2 sel_a",  {29'd0, fa_c}, 32'd0);
        check("fl3 br1 sel_a",  {29'd0, fa_d}, 32'd1);
        tick();

        // Reload while counting
        drive(1'b1, ADDI_1, 1'b1);
        tick();
        drive(1'b1, ADDI_1, 1'b0);
        check("rl1 flush", {31'd0, fl_c}, 32'd1);
        tick();
        drive(1'b1, ADDI_1, 1'b1);
        check("rl2 flush", {31'd0, fl_c}, 32'd1);
        tick();
        drive(1'b1, ADDI_1, 1'b0);
        check("rl3 flush", {31'd0, fl_c}, 32'd1);
        tick();
        drive(1'b1, ADDI_1, 1'b0);
        check("rl4 flush", {31'd0, fl_c}, 32'd1);
        tick();
        drive(1'b1, ADDI_1, 1'b0);
        check("rl5 flush", {31'd0, fl_c}, 32'd0);
        tick();

        // Async reset mid-stall
        drive(1'b1, LW_4, 1'b0);
        tick();
        drive(1'b1, NOR_544, 1'b0);
        check("ar stall before", {31'd0, st_d}, 32'd1);
        check("ar cnt before",   {30'd0, sc_d}, 32'd1);
        rst = 1'b1;
        #1;
        check("ar stall",     {31'd0, st_d}, 32'd0);
        check("ar sel_a",     {29'd0, fa_d}, 32'd0);
        check("ar stall_cnt", {30'd0, sc_d}, 32'd0);
        rst = 1'b0;
        #1;
        check("ar post stall", {31'd0, st_d}, 32'd0);
        check("ar post sel_a", {29'd0, fa_d}, 32'd0);
        check("ar post issue", {31'd0, iv_d}, 32'd1);
        tick();

        // Saturation of a 2-bit stall counter after four stalls
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, LW_4, 1'b0);
            tick();
            drive(1'b1, NOR_544, 1'b0);
            tick();
            drive(1'b1, NOR_544, 1'b0);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0);
        check("sat stall_cnt", {30'd0, sc_d}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
